apb_mem_ctrl: RTL and testbench

- APB3 slave controller that sequences the 256x8 synchronous memory (ce/wren/rden strobes, registered read data).
- Converts APB setup/access phases into single-cycle memory strobes and inserts wait states through PREADY.
- Sits between the APB interconnect and the memory instance. It is the only master of the memory ports.

---
 rtl/apb_mem_ctrl_if.sv | 22 ++
 rtl/apb_mem_ctrl.sv | 108 ++++++++++
 tb/tb_apb_mem_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/apb_mem_ctrl_if.sv
// apb_mem_ctrl_if: APB3 bus bundle between an APB master and the memory controller slave
interface apb_mem_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) ();
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;
  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );
  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_mem_ctrl.sv
// apb_mem_ctrl: APB3 slave sequencing a synchronous memory; define MEM_WP_EN to write-protect addresses up to WP_LIMIT
module apb_mem_ctrl #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 8,
  parameter logic [ADDR_W-1:0] WP_LIMIT = 'h0F
) (
  input  logic              clk,
  input  logic              rst,
  apb_mem_ctrl_if.slave     apb,
  output logic              o_mem_ce,
  output logic              o_mem_wren,
  output logic              o_mem_rden,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wr_data,
  input  logic [DATA_W-1:0] i_mem_rd_data
);
`ifdef MEM_WP_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, MEM, RWAIT, DONE} state_t;
  state_t            r_state, w_next;
  logic              r_ce, r_wren, r_rden, r_pready, r_pslverr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_prdata;
  logic              w_ce, w_wren, w_rden, w_pready, w_pslverr;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata, w_prdata;
  logic              w_setup, w_wp;
  assign w_setup = apb.psel && !apb.penable;
  assign w_wp    = WP_EN && apb.pwrite && (apb.paddr <= WP_LIMIT);
  // next state and next registered outputs; strobes and pready default low so each lasts one cycle
  always_comb begin
    w_next    = r_state;
    w_ce      = 1'b0;
    w_wren    = 1'b0;
    w_rden    = 1'b0;
    w_pready  = 1'b0;
    w_pslverr = 1'b0;
    w_addr    = r_addr;
    w_wdata   = r_wdata;
    w_prdata  = r_prdata;
    case (r_state)
      IDLE: if (w_setup) begin
        w_addr  = apb.paddr;
        w_wdata = apb.pwdata;
        if (w_wp) begin
          w_next    = DONE;
          w_pready  = 1'b1;
          w_pslverr = 1'b1;
        end else begin
          w_next = MEM;
          w_ce   = 1'b1;
          w_wren = apb.pwrite;
          w_rden = !apb.pwrite;
        end
      end
      MEM: begin
        w_next   = !apb.psel ? IDLE : r_wren ? DONE : RWAIT;
        w_pready = apb.psel && r_wren;
      end
      RWAIT: if (apb.psel) begin
        w_prdata = i_mem_rd_data;
        w_pready = 1'b1;
        w_next   = DONE;
      end else begin
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  // output registers; reset clears any strobe already launched
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ce      <= 1'b0;
      r_wren    <= 1'b0;
      r_rden    <= 1'b0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_prdata  <= '0;
    end else begin
      r_ce      <= w_ce;
      r_wren    <= w_wren;
      r_rden    <= w_rden;
      r_pready  <= w_pready;
      r_pslverr <= w_pslverr;
      r_addr    <= w_addr;
      r_wdata   <= w_wdata;
      r_prdata  <= w_prdata;
    end
  end
  assign o_mem_ce      = r_ce;
  assign o_mem_wren    = r_wren;
  assign o_mem_rden    = r_rden;
  assign o_mem_addr    = r_addr;
  assign o_mem_wr_data = r_wdata;
  assign apb.prdata    = r_prdata;
  assign apb.pready    = r_pready;
  assign apb.pslverr   = r_pslverr;
endmodule

// File: tb/tb_apb_mem_ctrl.sv
// tb_apb_mem_ctrl: directed vector bench for apb_mem_ctrl with a 256x8 synchronous memory model
module tb_apb_mem_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       mem_ce, mem_wren, mem_rden;
  logic [7:0] mem_addr, mem_wr_data, mem_rd_data;
  logic [7:0] mem [256];
  int         n_err = 0, n_chk = 0;
  int         n_ce, n_wr, n_rd, n_both, n_dbl;
  logic       prev_ce = 1'b0;
  apb_mem_ctrl_if bus ();
  apb_mem_ctrl dut (
    .clk(clk), .rst(rst), .apb(bus.slave),
    .o_mem_ce(mem_ce), .o_mem_wren(mem_wren), .o_mem_rden(mem_rden),
    .o_mem_addr(mem_addr), .o_mem_wr_data(mem_wr_data), .i_mem_rd_data(mem_rd_data)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
    end else begin
      if (mem_ce && mem_wren) mem[mem_addr] <= mem_wr_data;
      if (mem_ce && mem_rden) mem_rd_data <= mem[mem_addr];
    end
  end
  always @(posedge clk) begin
    if (mem_ce) n_ce = n_ce + 1;
    if (mem_wren) n_wr = n_wr + 1;
    if (mem_rden) n_rd = n_rd + 1;
    if (mem_rden && mem_wren) n_both = n_both + 1;
    if (mem_ce && prev_ce) n_dbl = n_dbl + 1;
    prev_ce = mem_ce;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic clr_cnt();
    n_ce = 0; n_wr = 0; n_rd = 0; n_both = 0; n_dbl = 0;
  endtask
  task automatic xfer(input logic wr, input logic [7:0] a, input logic [7:0] d,
                      output logic [7:0] rd, output int cyc, output logic err);
    @(posedge clk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr; bus.paddr = a; bus.pwdata = d;
    clr_cnt();
    cyc = 1;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    cyc = 2;
    while (!bus.pready && cyc < 12) begin
      @(posedge clk); #1;
      cyc++;
    end
    rd  = bus.prdata;
    err = bus.pslverr;
  endtask
  task automatic idle();
    @(posedge clk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, " prdata"}, bus.prdata, 0);
    chk({tag, " pready"}, bus.pready, 0);
    chk({tag, " pslverr"}, bus.pslverr, 0);
    chk({tag, " mem_ce"}, mem_ce, 0);
    chk({tag, " mem_wren"}, mem_wren, 0);
    chk({tag, " mem_rden"}, mem_rden, 0);
    chk({tag, " mem_addr"}, mem_addr, 0);
    chk({tag, " mem_wr_data"}, mem_wr_data, 0);
  endtask
  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
  } vec_t;
  vec_t v [12];
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [7:0] rd;
    int         cyc;
    logic       err;
    string      s;
    v[0]  = '{1'b1, 8'h40, 8'hA5, 8'h00};
    v[1]  = '{1'b0, 8'h40, 8'h00, 8'hA5};
    v[2]  = '{1'b0, 8'h10, 8'h00, 8'h10};
    v[3]  = '{1'b0, 8'h11, 8'h00, 8'h11};
    v[4]  = '{1'b0, 8'hFF, 8'h00, 8'hFF};
    v[5]  = '{1'b1, 8'hC3, 8'h3C, 8'h00};
    v[6]  = '{1'b0, 8'hC3, 8'h00, 8'h3C};
    v[7]  = '{1'b1, 8'hFF, 8'h5A, 8'h00};
    v[8]  = '{1'b0, 8'hFF, 8'h00, 8'h5A};
    v[9]  = '{1'b1, 8'h80, 8'hE7, 8'h00};
    v[10] = '{1'b0, 8'h80, 8'h00, 8'hE7};
    v[11] = '{1'b0, 8'h7F, 8'h00, 8'h7F};
    rst = 1'b1;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = '0; bus.pwdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      xfer(v[i].wr, v[i].addr, v[i].wdata, rd, cyc, err);
      s = $sformatf("vec%0d", i);
      chk({s, " cycles"}, cyc, v[i].wr ? 3 : 4);
      chk({s, " ce_pulses"}, n_ce, 1);
      chk({s, " wren_pulses"}, n_wr, {31'b0, v[i].wr});
      chk({s, " rden_pulses"}, n_rd, {31'b0, !v[i].wr});
      chk({s, " rden_and_wren"}, n_both, 0);
      chk({s, " ce_width"}, n_dbl, 0);
      chk({s, " pslverr"}, err, 0);
      if (!v[i].wr) chk({s, " prdata"}, rd, v[i].exp_rd);
    end
    xfer(1'b0, 8'h33, 8'h00, rd, cyc, err);
    chk("pre_abort prdata", rd, 8'h33);
    @(posedge clk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 8'h20;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    @(posedge clk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0;
    @(posedge clk); #1;
    chk("abort pready", bus.pready, 0);
    chk("abort prdata", bus.prdata, 8'h33);
    xfer(1'b0, 8'h21, 8'h00, rd, cyc, err);
    chk("post_abort prdata", rd, 8'h21);
    chk("post_abort cycles", cyc, 4);
    chk("post_abort ce_pulses", n_ce, 1);
    @(posedge clk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 8'h30;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; bus.psel = 1'b0; bus.penable = 1'b0;
    chk_zero("mid_reset");
    clr_cnt();
    repeat (4) @(posedge clk);
    #1;
    chk("post_reset no_ce", n_ce, 0);
    xfer(1'b0, 8'h30, 8'h00, rd, cyc, err);
    chk("post_reset prdata", rd, 8'h30);
    chk("post_reset cycles", cyc, 4);
`ifdef MEM_WP_EN
    xfer(1'b1, 8'h05, 8'h77, rd, cyc, err);
    chk("wp_low cycles", cyc, 2);
    chk("wp_low pslverr", err, 1);
    chk("wp_low ce_pulses", n_ce, 0);
    xfer(1'b0, 8'h05, 8'h00, rd, cyc, err);
    chk("wp_low readback", rd, 8'h05);
    chk("wp_low read pslverr", err, 0);
    xfer(1'b1, 8'h10, 8'h77, rd, cyc, err);
    chk("wp_edge cycles", cyc, 3);
    chk("wp_edge pslverr", err, 0);
    xfer(1'b0, 8'h10, 8'h00, rd, cyc, err);
    chk("wp_edge readback", rd, 8'h77);
`else
    xfer(1'b1, 8'h05, 8'h77, rd, cyc, err);
    chk("low_write cycles", cyc, 3);
    chk("low_write pslverr", err, 0);
    chk("low_write ce_pulses", n_ce, 1);
    xfer(1'b0, 8'h05, 8'h00, rd, cyc, err);
    chk("low_write readback", rd, 8'h77);
`endif
    idle();
    @(posedge clk); #1;
    chk("final pready", bus.pready, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
